pipe_sub_16bit: RTL

Pipelined 16-bit subtractor computing `a - b - bin` as four 4-bit slices, one slice per stage, with the borrow rippling through registered stage boundaries. It is the inverse arithmetic path to the team's pipelined 16-bit adder and sits in the same datapath. It adds a valid/ready handshake with a global stall, so results are never dropped when the consumer back-pressures.

---
 rtl/pipe_sub_16bit_pkg.sv | 17 +
 rtl/pipe_sub_16bit_if.sv | 28 ++
 rtl/pipe_sub_16bit_slice.sv | 17 +
 rtl/pipe_sub_16bit.sv | 97 +++++++++
 4 files changed

// File: rtl/pipe_sub_16bit_pkg.sv
// Shared constants and the per-stage register bundle for the pipelined subtractor.
package pipe_sub_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned STAGES = WIDTH / SLICE;

  // Operands travel full width; each stage only consumes its own slice of them.
  typedef struct packed {
    logic             valid;
    logic             borrow;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
  } stage_t;

endpackage

// File: rtl/pipe_sub_16bit_if.sv
// Operand/result handshake bundle for pipe_sub_16bit.
interface pipe_sub_16bit_if;
  import pipe_sub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, neg, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, neg, ovf
  );

endinterface

// File: rtl/pipe_sub_16bit_slice.sv
// Combinational SLICE-bit subtractor: a - b - bin via a + ~b + ~bin.
module sub_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic carry;

  assign {carry, d} = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bin};
  assign bout = ~carry;

endmodule

// File: rtl/pipe_sub_16bit.sv
// Pipelined subtractor, one SLICE per stage, global-stall valid/ready handshake.
// Optional result flags enabled by defining PIPE_SUB_FLAGS_EN.
module pipe_sub_16bit #(
  parameter int unsigned WIDTH  = pipe_sub_pkg::WIDTH,
  parameter int unsigned SLICE  = pipe_sub_pkg::SLICE,
  parameter int unsigned STAGES = pipe_sub_pkg::STAGES
) (
  input  logic             clk,
  input  logic             reset,
  pipe_sub_16bit_if.slave  bus
);

  typedef pipe_sub_pkg::stage_t stage_t;

  stage_t           src  [STAGES];
  stage_t           st_d [STAGES];
  stage_t           st_q [STAGES];
  logic [SLICE-1:0] sd   [STAGES];
  logic             sbo  [STAGES];
  logic             adv;

  assign adv          = !st_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    src[0] = '{valid: bus.in_valid, borrow: bus.bin, opa: bus.a, opb: bus.b, res: '0};
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    sub_slice #(.SLICE(SLICE)) u_slice (
      .a    (src[j].opa[SLICE*j +: SLICE]),
      .b    (src[j].opb[SLICE*j +: SLICE]),
      .bin  (src[j].borrow),
      .d    (sd[j]),
      .bout (sbo[j])
    );
  end

  // Each stage replaces the incoming borrow with its own and drops its slice into res.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      st_d[k]                      = src[k];
      st_d[k].borrow               = sbo[k];
      st_d[k].res[SLICE*k +: SLICE] = sd[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.diff      = st_q[STAGES-1].res[WIDTH-1:0];
  assign bus.bout      = st_q[STAGES-1].borrow;

`ifdef PIPE_SUB_FLAGS_EN
  stage_t fin_d;
  logic   zero_q;
  logic   neg_q;
  logic   ovf_q;

  assign fin_d = st_d[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      zero_q <= (fin_d.res == '0);
      neg_q  <= fin_d.res[WIDTH-1];
      ovf_q  <= (fin_d.opa[WIDTH-1] != fin_d.opb[WIDTH-1]) &&
                (fin_d.res[WIDTH-1] != fin_d.opa[WIDTH-1]);
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.neg  = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule
